// File: rtl/microcode_sequencer_pkg.sv
// microcode_sequencer_pkg: control-word field positions, sequencing encodings and address defaults
package microcode_sequencer_pkg;
  localparam int UADDR_W_DEF = 10;
  localparam int UWORD_W_DEF = 44;
  localparam int IR_WE_BIT = 27;
  localparam int NEXT_SEL_LO = 28;
  localparam int NEXT_SEL_HI = 29;
  localparam int NEXT_LO = 30;
  localparam int NEXT_HI = 39;
  localparam int PRIV_WE_BIT = 40;
  localparam int PRIV_SET_BIT = 41;
  localparam int RST_OUT_BIT = 42;
  localparam logic [UADDR_W_DEF-1:0] RESET_ADDR_DEF = 10'h000;
  localparam logic [UADDR_W_DEF-1:0] TRAP_ADDR_DEF = 10'h3F8;
  typedef enum logic [1:0] {
    SEQ_INC = 2'b00,
    SEQ_JMP = 2'b01,
    SEQ_DISPATCH = 2'b10,
    SEQ_COND = 2'b11
  } seq_sel_e;
endpackage

// File: rtl/microcode_next_addr.sv
// microcode_next_addr: combinational next micro-address selection with privilege trap detection
module microcode_next_addr
  import microcode_sequencer_pkg::*;
#(
  parameter int UADDR_W = UADDR_W_DEF,
  parameter logic [UADDR_W-1:0] RESET_ADDR = RESET_ADDR_DEF,
  parameter logic [UADDR_W-1:0] TRAP_ADDR = TRAP_ADDR_DEF
) (
  input  logic [UADDR_W-1:0] upc,
  input  logic [1:0]         sel,
  input  logic [UADDR_W-1:0] next_field,
  input  logic               cond,
  input  logic [6:0]         op_eff,
  input  logic               priv_level,
  input  logic               rst_out,
  output logic [UADDR_W-1:0] next_upc,
  output logic               trap
);
  logic [UADDR_W-1:0] upc_inc;
  // soft reset beats a trap, a trap beats the selected sequencing mode
  always_comb begin
    upc_inc = upc + UADDR_W'(1);
    trap = !rst_out && sel == SEQ_DISPATCH && op_eff[6] && !priv_level;
    next_upc = rst_out ? RESET_ADDR :
               trap ? TRAP_ADDR :
               sel == SEQ_JMP ? next_field :
               sel == SEQ_DISPATCH ? UADDR_W'({op_eff, 3'b000}) :
               (sel == SEQ_COND && cond) ? next_field : upc_inc;
  end
endmodule

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: micro-PC, IR and privilege state driving the microcode ROM and control word
module microcode_sequencer
  import microcode_sequencer_pkg::*;
#(
  parameter int UADDR_W = UADDR_W_DEF,
  parameter int UWORD_W = UWORD_W_DEF,
  parameter logic [UADDR_W-1:0] RESET_ADDR = RESET_ADDR_DEF,
  parameter logic [UADDR_W-1:0] TRAP_ADDR = TRAP_ADDR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               cond,
  input  logic [15:0]        bus_in,
  output logic [UADDR_W-1:0] rom_addr,
  input  logic [UWORD_W-1:0] rom_data,
  output logic [UWORD_W-1:0] uword,
  output logic [15:0]        ir,
  output logic               priv_level,
  output logic               trap,
  output logic               soft_rst
);
  logic [UADDR_W-1:0] upc, next_upc;
  logic active, ir_we, rst_out, trap_raw;
  logic [6:0] op_eff;
  // decode the current word; all side effects are gated off during reset and stall
  always_comb begin
    active = !rst && !stall;
    ir_we = rom_data[IR_WE_BIT];
    rst_out = rom_data[RST_OUT_BIT];
    op_eff = ir_we ? bus_in[15:9] : ir[15:9];
    uword = active ? rom_data : '0;
    trap = active && trap_raw;
    soft_rst = active && rst_out;
    rom_addr = upc;
  end
  microcode_next_addr #(
    .UADDR_W(UADDR_W),
    .RESET_ADDR(RESET_ADDR),
    .TRAP_ADDR(TRAP_ADDR)
  ) u_next (
    .upc(upc),
    .sel(rom_data[NEXT_SEL_HI:NEXT_SEL_LO]),
    .next_field(rom_data[NEXT_HI:NEXT_LO]),
    .cond(cond),
    .op_eff(op_eff),
    .priv_level(priv_level),
    .rst_out(rst_out),
    .next_upc(next_upc),
    .trap(trap_raw)
  );
  // sequencer state: hold on stall, soft reset and trap force kernel level
  always_ff @(posedge clk) begin
    if (rst) begin
      upc <= RESET_ADDR;
      ir <= '0;
      priv_level <= 1'b1;
    end else if (!stall) begin
      upc <= next_upc;
      ir <= rst_out ? '0 : ir_we ? bus_in : ir;
      priv_level <= (rst_out || trap_raw) ? 1'b1 :
                    rom_data[PRIV_WE_BIT] ? rom_data[PRIV_SET_BIT] : priv_level;
    end
  end
endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Microprogram sequencer that sits directly upstream of the control-word splitter.
- Holds the micro-PC, instruction register and privilege level, and addresses the microcode ROM.
- Presents the 44-bit control word to the splitter each cycle.
- Computes the next micro-address from the word's DECODE_NEXT_SEL/DECODE_NEXT fields, the IR opcode and the ALU condition flag. Handles soft reset, stall and privilege traps.

Parameters:
- UADDR_W, 10, micro-address width (must equal DECODE_NEXT width).
- UWORD_W, 44, control word width.
- RESET_ADDR, 10'h000, micro-address entered on reset and soft reset.
- TRAP_ADDR, 10'h3F8, micro-address entered on privilege violation.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  memory/IO wait; freezes the sequencer.
- cond  in  1  ALU condition flag for conditional micro-branch.
- bus_in  in  16  data bus; source for IR load.
- rom_addr  out  10  micro-PC to the microcode ROM (registered).
- rom_data  in  44  ROM word at rom_addr (asynchronous read, same cycle).
- uword  out  44  control word to the splitter.
- ir  out  16  instruction register.
- priv_level  out  1  1 = kernel, 0 = user.
- trap  out  1  one-cycle pulse on privilege violation.
- soft_rst  out  1  one-cycle pulse when a word with RST_OUT executes.

Behaviour:
- Field positions used from rom_data:
  - IR_WE = bit 27.
  - DECODE_NEXT_SEL = bits 29:28.
  - DECODE_NEXT = bits 39:30.
  - PRIVILAGE_WE = bit 40.
  - PRIVILAGE_SET_LEVEL = bit 41.
  - RST_OUT = bit 42.
- Reset (rst=1 at clock edge): upc=RESET_ADDR, ir=0, priv_level=1, trap=0, soft_rst=0.
- While rst=1, uword is forced to 0 combinationally.
- One microstep per cycle. uword = rom_data when !rst && !stall, else 0 (no side effects while stalled).
- stall=1: upc, ir and priv_level hold; trap=0, soft_rst=0. The same word re-executes on the first cycle with stall=0.
- IR: if IR_WE, ir <= bus_in at the edge.
- Effective opcode, op_eff:
  - op_eff = bus_in[15:9] when IR_WE is set in the current word (bypass, so dispatch works in the load cycle).
  - Otherwise op_eff = ir[15:9].
- Next address by DECODE_NEXT_SEL:
  - 00: upc+1, mod 1024 (1023 wraps to 0).
  - 01: DECODE_NEXT.
  - 10: dispatch, {op_eff, 3'b000}.
  - 11: DECODE_NEXT if cond=1, else upc+1.
- Privilege check on dispatch:
  - Violation when op_eff[6]=1 (privileged opcode class) and priv_level=0.
  - On violation: next upc=TRAP_ADDR, trap=1 for that cycle, priv_level<=1.
  - IR load in the same word still occurs.
- PRIVILAGE_WE: priv_level <= PRIVILAGE_SET_LEVEL.
  - The check in the same word uses the old level.
  - A trap overrides PRIVILAGE_WE and forces 1.
- RST_OUT: soft_rst=1 for the cycle. Next upc=RESET_ADDR, ir<=0, priv_level<=1.
  - Overrides all other next-address selection and IR_WE.
  - trap is suppressed.
- Priority, highest first: rst > stall > RST_OUT > trap > DECODE_NEXT_SEL.
- rst asserted mid-stall or mid-dispatch: reset wins on that edge. No partial IR/priv updates.
- Latency: a control word is visible on uword in the same cycle as its address on rom_addr. Its next-address effect appears on rom_addr one cycle later.

Decomposition:
- Shared package holds:
  - Bit-position constants for every control-word field (same positions the splitter uses).
  - DECODE_NEXT_SEL encodings: SEQ_INC=2'b00, SEQ_JMP=2'b01, SEQ_DISPATCH=2'b10, SEQ_COND=2'b11.
  - RESET_ADDR/TRAP_ADDR defaults.
- One sub-module is natural: microcode_next_addr.
  - Purely combinational.
  - Inputs: upc, sel, next field, cond, op_eff, priv_level, rst_out.
  - Outputs: next upc and trap.
- ROM stays outside the block.

Test Plan:
- Reset, then rom_data with sel=00, held 3 cycles -> rom_addr 0,1,2,3; uword=0 during rst, equals rom_data afterwards; priv_level=1.
- upc=1023, sel=00 -> rom_addr=0 next cycle; sel=01 with DECODE_NEXT=10'h155 -> rom_addr=10'h155.
- Word with IR_WE=1, sel=10, bus_in=16'h0A00 (op=5) -> rom_addr=10'h028 next cycle; ir=16'h0A00.
- priv_level=0 (via PRIVILAGE_WE with SET_LEVEL=0), dispatch bus_in=16'h8000 -> trap=1 pulse, rom_addr=TRAP_ADDR, priv_level=1.
- sel=11, DECODE_NEXT=10'h200, upc=10'h040: cond=1 -> rom_addr=10'h200; cond=0 -> 10'h041. With stall=1 for 2 cycles, rom_addr holds and uword=0.
- RST_OUT=1 together with sel=01 and IR_WE=1 -> soft_rst=1 one cycle, rom_addr=RESET_ADDR, ir=0, priv_level=1.
